robm_in_cond: RTL



---
 rtl/robm_in_cond_if.sv | 22 ++
 rtl/robm_in_cond.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/robm_in_cond_if.sv
// Handshake bundle between the condition sources and the robm input-conditioning stage.
// Optional glitch_cnt is present only when ROBM_IN_COND_GLITCH_CNT_EN is defined.
interface robm_in_cond_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] raw_in;
  logic             en;
  logic [WIDTH-1:0] x_out;
  logic             x_valid;
  logic             x_change;
`ifdef ROBM_IN_COND_GLITCH_CNT_EN
  logic [7:0]       glitch_cnt;
`endif

`ifdef ROBM_IN_COND_GLITCH_CNT_EN
  modport master (output raw_in, en, input x_out, x_valid, x_change, glitch_cnt);
  modport slave  (input raw_in, en, output x_out, x_valid, x_change, glitch_cnt);
`else
  modport master (output raw_in, en, input x_out, x_valid, x_change);
  modport slave  (input raw_in, en, output x_out, x_valid, x_change);
`endif
endinterface

// File: rtl/robm_in_cond.sv
// Synchronises, debounces and registers the x1..x12 condition lines for the robm controller.
// Define ROBM_IN_COND_GLITCH_CNT_EN to add the saturating rejected-pulse counter glitch_cnt.
module robm_in_cond #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  robm_in_cond_if.slave bus
);

  localparam int unsigned SET_W       = CNT_W + 1;
  localparam int unsigned SETTLE_LAST = DB_CYCLES + 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SETTLE,
    ST_RUN,
    ST_FROZEN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_s1;
  logic [WIDTH-1:0]   r_s2;
  logic [WIDTH-1:0]   r_x_out;
  logic [WIDTH-1:0]   w_x_out_nxt;
  logic               r_x_valid;
  logic               w_x_valid_nxt;
  logic               r_x_change;
  logic               w_x_change_nxt;
  logic [SET_W-1:0]   r_settle;
  logic [SET_W-1:0]   w_settle_nxt;
  logic [CNT_W-1:0]   r_cnt     [WIDTH];
  logic [CNT_W-1:0]   w_cnt_nxt [WIDTH];

  // Two-flop synchroniser; everything downstream sees only r_s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.raw_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_x_out    <= '0;
      r_x_valid  <= 1'b0;
      r_x_change <= 1'b0;
      r_settle   <= '0;
      r_cnt      <= '{default: '0};
    end else begin
      r_state    <= w_state_nxt;
      r_x_out    <= w_x_out_nxt;
      r_x_valid  <= w_x_valid_nxt;
      r_x_change <= w_x_change_nxt;
      r_settle   <= w_settle_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next state, settle sequencing and per-bit debounce; counts clear outside active RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_x_out_nxt    = r_x_out;
    w_x_valid_nxt  = r_x_valid;
    w_x_change_nxt = 1'b0;
    w_settle_nxt   = r_settle;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = '0;
    end

    case (r_state)
      ST_INIT: begin
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_x_out_nxt = r_s2;
        if (r_settle == SET_W'(SETTLE_LAST)) begin
          w_state_nxt   = ST_RUN;
          w_x_valid_nxt = 1'b1;
        end else begin
          w_settle_nxt = r_settle + SET_W'(1);
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          w_state_nxt = ST_FROZEN;
        end else begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (r_s2[i] == r_x_out[i]) begin
              w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
              w_x_out_nxt[i] = ~r_x_out[i];
              w_x_change_nxt = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
        end
      end
      ST_FROZEN: begin
        if (bus.en) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

`ifdef ROBM_IN_COND_GLITCH_CNT_EN
  logic       w_reject_c;
  logic [7:0] r_glitch_cnt;

  // A rejected pulse: a bit returned to x_out while its debounce count was running.
  always_comb begin
    w_reject_c = 1'b0;
    if ((r_state == ST_RUN) && bus.en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if ((r_s2[i] == r_x_out[i]) && (r_cnt[i] != '0)) begin
          w_reject_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glitch_cnt <= '0;
    end else if (w_reject_c && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign bus.glitch_cnt = r_glitch_cnt;
`endif

  assign bus.x_out    = r_x_out;
  assign bus.x_valid  = r_x_valid;
  assign bus.x_change = r_x_change;

endmodule
